// File: rtl/hc_pkg.sv
// Shared FSM state type and default sizing constants for the hc read scheduler.
package hc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } sched_state_t;

  localparam int MAX_BURST_DEF  = 256;
  localparam int CREDIT_MAX_DEF = 512;
  localparam int LEN_W          = 10;

endpackage

// File: rtl/hc_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr,
// wrapping around the request vector.
module hc_rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic             o_valid
);

  int w_best;
  int w_dist;

  // Pick the active request with the smallest wrap-around distance from the pointer
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_best  = N;
    w_dist  = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i + N - int'(i_ptr)) % N;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hc_read_scheduler.sv
// Credit-based read-command scheduler sharing one read channel among NUM_REQ requesters.
// Define HC_READ_SCHED_STATS_EN to add the stat_stall back-pressure counter output.
module hc_read_scheduler
  import hc_pkg::*;
#(
  parameter int  NUM_REQ    = 2,
  parameter int  MAX_BURST  = MAX_BURST_DEF,
  parameter int  CREDIT_MAX = CREDIT_MAX_DEF,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_REQ-1:0]    req_en,
  input  logic [NUM_REQ*32-1:0] req_total,
  input  logic [NUM_REQ-1:0]    credit_ret,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ID_W-1:0]       cmd_req_id,
  output logic [LEN_W-1:0]      cmd_len,
`ifdef HC_READ_SCHED_STATS_EN
  output logic [31:0]           stat_stall,
`endif
  output logic                  busy,
  output logic                  done
);

  localparam int CR_W = $clog2(CREDIT_MAX + 1);

  sched_state_t     r_state;
  logic             r_cmd_valid;
  logic             r_busy;
  logic             r_done;
  logic [ID_W-1:0]  r_cmd_req_id;
  logic [ID_W-1:0]  r_ptr;
  logic [LEN_W-1:0] r_cmd_len;
  logic [31:0]      r_remaining [NUM_REQ];
  logic [CR_W-1:0]  r_credits   [NUM_REQ];
`ifdef HC_READ_SCHED_STATS_EN
  logic [31:0]      r_stat_stall;
`endif

  logic [LEN_W-1:0]   w_len       [NUM_REQ];
  logic [31:0]        w_rem_next  [NUM_REQ];
  logic [CR_W-1:0]    w_cred_next [NUM_REQ];
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_grant_valid;
  logic [ID_W-1:0]    w_grant_id;
  logic               w_hs;
  logic               w_all_zero;
  logic               w_all_full;
  logic [31:0]        w_dec;
  logic [31:0]        w_sum;

  assign w_hs = (r_state == S_ISSUE) && r_cmd_valid && cmd_ready;

  // A requester may only be granted a burst its receive FIFO can fully absorb
  always_comb begin
    w_all_zero = 1'b1;
    w_all_full = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_len[i]  = (r_remaining[i] > 32'(MAX_BURST)) ? LEN_W'(MAX_BURST) : LEN_W'(r_remaining[i]);
      w_elig[i] = (r_remaining[i] != 32'd0) && (32'(r_credits[i]) >= 32'(w_len[i]));
      if (r_remaining[i] != 32'd0) w_all_zero = 1'b0;
      if (r_credits[i] != CR_W'(CREDIT_MAX)) w_all_full = 1'b0;
    end
  end

  hc_rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_arb (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_valid (w_grant_valid)
  );

  // Credit returns land even on a handshake cycle; the sum saturates at CREDIT_MAX
  always_comb begin
    w_grant_id = '0;
    w_dec      = 32'd0;
    w_sum      = 32'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_grant_id = ID_W'(i);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dec          = (w_hs && (int'(r_cmd_req_id) == i)) ? 32'(r_cmd_len) : 32'd0;
      w_rem_next[i]  = r_remaining[i] - w_dec;
      w_sum          = 32'(r_credits[i]) - w_dec + 32'(credit_ret[i]);
      w_cred_next[i] = (w_sum > 32'(CREDIT_MAX)) ? CR_W'(CREDIT_MAX) : CR_W'(w_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cmd_valid  <= 1'b0;
      r_cmd_req_id <= '0;
      r_cmd_len    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ptr        <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_remaining[i] <= 32'd0;
        r_credits[i]   <= CR_W'(CREDIT_MAX);
      end
`ifdef HC_READ_SCHED_STATS_EN
      r_stat_stall <= 32'd0;
`endif
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_remaining[i] <= w_rem_next[i];
        r_credits[i]   <= w_cred_next[i];
      end
`ifdef HC_READ_SCHED_STATS_EN
      if (r_cmd_valid && !cmd_ready && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 32'd1;
`endif
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int i = 0; i < NUM_REQ; i++) begin
              r_remaining[i] <= req_en[i] ? req_total[i*32 +: 32] : 32'd0;
              r_credits[i]   <= CR_W'(CREDIT_MAX);
            end
            r_ptr   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= S_ARB;
`ifdef HC_READ_SCHED_STATS_EN
            r_stat_stall <= 32'd0;
`endif
          end
        end
        S_ARB: begin
          if (w_all_zero) begin
            r_state <= S_DRAIN;
          end else if (w_grant_valid) begin
            r_cmd_req_id <= w_grant_id;
            r_cmd_len    <= w_len[w_grant_id];
            r_cmd_valid  <= 1'b1;
            r_ptr        <= ID_W'((int'(w_grant_id) + 1) % NUM_REQ);
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= S_ARB;
          end
        end
        S_DRAIN: begin
          if (w_all_full) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_valid  = r_cmd_valid;
  assign cmd_req_id = r_cmd_req_id;
  assign cmd_len    = r_cmd_len;
  assign busy       = r_busy;
  assign done       = r_done;
`ifdef HC_READ_SCHED_STATS_EN
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_hc_read_scheduler.sv
// Directed self-checking bench for hc_read_scheduler (NUM_REQ=2, MAX_BURST=256, CREDIT_MAX=512).
module tb_hc_read_scheduler;
  import hc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  req_en;
  logic [63:0] req_total;
  logic [1:0]  credit_ret;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [0:0]  cmd_req_id;
  logic [9:0]  cmd_len;
  logic        busy;
  logic        done;
`ifdef HC_READ_SCHED_STATS_EN
  logic [31:0] stat_stall;
`endif

  int   assertCount = 0;
  int   failCount   = 0;
  int   owed [2];
  int   retCount;
  logic [1:0] retEn;
  int   qId [$];
  int   qLen [$];

  always #5 clk = ~clk;

  hc_read_scheduler #(
    .NUM_REQ    (2),
    .MAX_BURST  (256),
    .CREDIT_MAX (512)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .req_en     (req_en),
    .req_total  (req_total),
    .credit_ret (credit_ret),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_req_id (cmd_req_id),
    .cmd_len    (cmd_len),
`ifdef HC_READ_SCHED_STATS_EN
    .stat_stall (stat_stall),
`endif
    .busy       (busy),
    .done       (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: log handshakes, account returned credits, drive the consumer model
  task automatic applyStimulus();
    logic hs;
    int   id;
    int   len;
    hs  = cmd_valid && cmd_ready;
    id  = int'(cmd_req_id);
    len = int'(cmd_len);
    @(posedge clk);
    #1;
    if (hs) begin
      qId.push_back(id);
      qLen.push_back(len);
      owed[id] += len;
    end
    for (int i = 0; i < 2; i++) begin
      if (credit_ret[i]) begin
        owed[i]--;
        retCount++;
      end
      if (retEn[i]) credit_ret[i] = (owed[i] > 0);
    end
  endtask

  task automatic clearBook();
    owed[0]  = 0;
    owed[1]  = 0;
    retCount = 0;
    qId.delete();
    qLen.delete();
  endtask

  task automatic doReset();
    reset      = 1'b1;
    start      = 1'b0;
    cmd_ready  = 1'b0;
    credit_ret = '0;
    retEn      = '0;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    clearBook();
  endtask

  task automatic pulseStart(input logic [1:0] en, input int t0, input int t1);
    credit_ret = '0;
    req_en     = en;
    req_total  = {32'(t1), 32'(t0)};
    start      = 1'b1;
    applyStimulus();
    start = 1'b0;
    clearBook();
  endtask

  task automatic waitDone(input string tag, input int bound);
    int n;
    n = 0;
    while (!done && (n < bound)) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  task automatic checkSeq(input string tag, input int n, input int id0, input int alt, input int len);
    checkOutput({tag, "_count"}, 32'(qId.size()), 32'(n));
    for (int k = 0; (k < qId.size()) && (k < n); k++) begin
      checkOutput($sformatf("%s_id%0d", tag, k), 32'(qId[k]), 32'(alt ? (id0 + k) % 2 : id0));
      checkOutput($sformatf("%s_len%0d", tag, k), 32'(qLen[k]), 32'(len));
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    req_en     = '0;
    req_total  = '0;
    credit_ret = '0;
    cmd_ready  = 1'b0;
    retEn      = '0;
    clearBook();
    doReset();

    checkOutput("rst_valid", 32'(cmd_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_len", 32'(cmd_len), 32'd0);
    checkOutput("rst_id", 32'(cmd_req_id), 32'd0);
    checkOutput("rst_state", 32'(dut.r_state), 32'(S_IDLE));

    credit_ret = 2'b01;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    credit_ret = '0;
    checkOutput("credit_saturate", 32'(dut.r_credits[0]), 32'd512);
    clearBook();

    // Two full requesters, credits returned as lines arrive
    cmd_ready = 1'b1;
    retEn     = 2'b11;
    pulseStart(2'b11, 1024, 1024);
    checkOutput("a_busy", 32'(busy), 32'd1);
    checkOutput("a_arb_valid", 32'(cmd_valid), 32'd0);
    applyStimulus();
    checkOutput("a_first_valid", 32'(cmd_valid), 32'd1);
    checkOutput("a_first_id", 32'(cmd_req_id), 32'd0);
    checkOutput("a_first_len", 32'(cmd_len), 32'd256);
    waitDone("a_done", 5000);
    checkSeq("a", 8, 0, 1, 256);
    checkOutput("a_busy_end", 32'(busy), 32'd0);

    // Single requester with a partial final burst
    retEn = 2'b01;
    pulseStart(2'b01, 300, 999);
    waitDone("b_done", 2000);
    checkOutput("b_retcount", 32'(retCount), 32'd300);
    checkOutput("b_count", 32'(qId.size()), 32'd2);
    if (qId.size() >= 2) begin
      checkOutput("b_id0", 32'(qId[0]), 32'd0);
      checkOutput("b_len0", 32'(qLen[0]), 32'd256);
      checkOutput("b_id1", 32'(qId[1]), 32'd0);
      checkOutput("b_len1", 32'(qLen[1]), 32'd44);
    end

    // Requester 1 never returns credits and starves
    retEn = 2'b01;
    pulseStart(2'b11, 512, 1024);
    for (int c = 0; c < 700; c++) applyStimulus();
    checkSeq("c", 4, 0, 1, 256);
    checkOutput("c_valid", 32'(cmd_valid), 32'd0);
    checkOutput("c_busy", 32'(busy), 32'd1);
    checkOutput("c_done", 32'(done), 32'd0);
    checkOutput("c_state", 32'(dut.r_state), 32'(S_ARB));
    req_en    = 2'b11;
    req_total = {32'd5, 32'd5};
    start     = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int c = 0; c < 10; c++) applyStimulus();
    checkOutput("c_ignore_count", 32'(qId.size()), 32'd4);
    checkOutput("c_ignore_busy", 32'(busy), 32'd1);
    checkOutput("c_ignore_state", 32'(dut.r_state), 32'(S_ARB));

    // Reset abandons a pending command
    doReset();
    pulseStart(2'b01, 10, 0);
    applyStimulus();
    checkOutput("d_valid_pre", 32'(cmd_valid), 32'd1);
    reset = 1'b1;
    applyStimulus();
    checkOutput("d_valid", 32'(cmd_valid), 32'd0);
    checkOutput("d_busy", 32'(busy), 32'd0);
    checkOutput("d_done", 32'(done), 32'd0);
    checkOutput("d_len", 32'(cmd_len), 32'd0);
    checkOutput("d_state", 32'(dut.r_state), 32'(S_IDLE));
    reset = 1'b0;
    clearBook();

    // Back-pressure: command fields hold while cmd_ready is low
    cmd_ready = 1'b0;
    retEn     = 2'b01;
    pulseStart(2'b01, 10, 0);
    applyStimulus();
    checkOutput("e_valid", 32'(cmd_valid), 32'd1);
    checkOutput("e_len", 32'(cmd_len), 32'd10);
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      checkOutput($sformatf("e_hold_valid%0d", c), 32'(cmd_valid), 32'd1);
      checkOutput($sformatf("e_hold_id%0d", c), 32'(cmd_req_id), 32'd0);
      checkOutput($sformatf("e_hold_len%0d", c), 32'(cmd_len), 32'd10);
    end
`ifdef HC_READ_SCHED_STATS_EN
    checkOutput("e_stat_stall", stat_stall, 32'd5);
`endif
    cmd_ready = 1'b1;
    applyStimulus();
    checkOutput("e_after_hs", 32'(cmd_valid), 32'd0);
    waitDone("e_done", 200);
    checkSeq("e", 1, 0, 0, 10);

    // Handshake and credit return on the same cycle
    retEn     = 2'b00;
    cmd_ready = 1'b1;
    pulseStart(2'b01, 512, 0);
    applyStimulus();
    applyStimulus();
    cmd_ready = 1'b0;
    applyStimulus();
    checkOutput("f_valid", 32'(cmd_valid), 32'd1);
    checkOutput("f_credits_pre", 32'(dut.r_credits[0]), 32'd256);
    credit_ret = 2'b01;
    cmd_ready  = 1'b1;
    applyStimulus();
    credit_ret = '0;
    checkOutput("f_credits", 32'(dut.r_credits[0]), 32'd1);
    checkOutput("f_remaining", dut.r_remaining[0], 32'd0);

    doReset();
    checkOutput("g_rst_credits", 32'(dut.r_credits[0]), 32'd512);
    checkOutput("g_rst_remaining", dut.r_remaining[1], 32'd0);

    // Empty jobs complete without issuing anything
    cmd_ready = 1'b1;
    pulseStart(2'b00, 100, 100);
    checkOutput("g_busy", 32'(busy), 32'd1);
    waitDone("g_done_en0", 10);
    checkOutput("g_count_en0", 32'(qId.size()), 32'd0);
    pulseStart(2'b11, 0, 0);
    checkOutput("g_done_cleared", 32'(done), 32'd0);
    waitDone("g_done_tot0", 10);
    checkOutput("g_count_tot0", 32'(qId.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/hc_read_scheduler.md
HC_READ_SCHEDULER -- requirements
Module: hc_read_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing the single buffer read-request channel.
REQ-002 SHALL have parameter MAX_BURST, default 256, largest line count per issued command.
REQ-003 SHALL have parameter CREDIT_MAX, default 512, per-requester receive-FIFO depth in lines.
REQ-004 SHALL have port clk  in  1  single clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that loads a job.
REQ-007 SHALL have port req_en  in  NUM_REQ  requester participates in the job.
REQ-008 SHALL have port req_total  in  NUM_REQ x 32  lines to read per requester, sampled at start.
REQ-009 SHALL have port credit_ret  in  NUM_REQ  one line dequeued by a requester; returns one credit.
REQ-010 SHALL have port cmd_valid  out  1  read command valid.
REQ-011 SHALL have port cmd_ready  in  1  read channel accepts the command.
REQ-012 SHALL have port cmd_req_id  out  clog2(NUM_REQ)  granted requester.
REQ-013 SHALL have port cmd_len  out  10  burst length in lines, 1..MAX_BURST.
REQ-014 SHALL have ports busy  out  1 (job active) and done  out  1 (job complete, sticky).

Function
REQ-015 SHALL implement FSM IDLE, ARB, ISSUE, DRAIN, DONE; start is honoured only in IDLE or DONE and ignored otherwise.
REQ-016 On start SHALL load remaining[i] = req_en[i] ? req_total[i] : 0, set credits[i] = CREDIT_MAX, clear done, and enter ARB.
REQ-017 Requester i is eligible in ARB when remaining[i] > 0 and credits[i] >= min(MAX_BURST, remaining[i]).
REQ-018 Grant SHALL be round-robin, starting from the requester after the last granted one; after start, search begins at requester 0.
REQ-019 On a grant, ARB SHALL register cmd_req_id/cmd_len and enter ISSUE; cmd_valid is asserted 2 cycles after the start pulse.
REQ-020 In ISSUE, cmd_valid, cmd_req_id and cmd_len SHALL hold stable until the cycle cmd_valid && cmd_ready, then return to ARB (one bubble cycle between commands).
REQ-021 At handshake SHALL subtract cmd_len from both remaining and credits of the granted requester.
REQ-022 credit_ret[i] SHALL add 1 to credits[i] every cycle, including a handshake cycle; net update = credits - cmd_len + credit_ret.
REQ-023 credit_ret when credits[i] == CREDIT_MAX SHALL be ignored (saturate, no wrap).
REQ-024 ARB with no eligible requester and some remaining > 0 SHALL stay in ARB with cmd_valid = 0.
REQ-025 ARB with all remaining == 0 SHALL enter DRAIN; DRAIN exits to DONE when every credits[i] == CREDIT_MAX.
REQ-026 A start with all req_en = 0 or all req_total = 0 SHALL reach DONE with no command issued.
REQ-027 busy SHALL be 1 in ARB, ISSUE and DRAIN; done SHALL be 1 only in DONE.

Reset
REQ-028 Reset SHALL force IDLE, cmd_valid = 0, cmd_req_id = 0, cmd_len = 0, busy = 0, done = 0, remaining = 0, credits = CREDIT_MAX, and RR pointer = 0 at the next clk edge.
REQ-029 Reset mid-job SHALL abandon the job, including a pending ISSUE command, with no handshake counted.

Configuration
REQ-030 With HC_READ_SCHED_STATS_EN defined, SHALL add output stat_stall  32: counts cycles with cmd_valid && !cmd_ready, cleared on reset and start, saturating at all-ones.
REQ-031 Without HC_READ_SCHED_STATS_EN, the port and counter SHALL be absent.

Structure
REQ-032 The scheduler FSM enum type and default constants (CREDIT_MAX, MAX_BURST) SHALL live in hc_pkg.
REQ-033 Round-robin grant SHALL be a sub-module hc_rr_arbiter (request vector, pointer in; one-hot grant, valid out).

Verification
REQ-034 NUM_REQ=2, req_total={1024,1024}, cmd_ready=1, credit_ret each line after issue -> 8 commands of len 256 alternating id 0,1,0,1..., then done=1.
REQ-035 req_total[0]=300, req_en=01 -> commands len 256 then 44 to id 0; done only after 300 credit_ret pulses.
REQ-036 Requester 1 never returns credits, req_total={512,1024} -> id 1 gets 2 x 256 then stalls; id 0 keeps being served; FSM stays in ARB, busy=1.
REQ-037 cmd_ready low for 5 cycles in ISSUE -> cmd fields stable for 5 cycles; with STATS_EN, stat_stall=5.
REQ-038 Handshake and credit_ret on the same cycle with credits=256 and len=256 -> credits=1.
REQ-039 Reset asserted while cmd_valid=1 -> next cycle cmd_valid=0, busy=0, state IDLE; start ignored while busy=1.
